// File: rtl/ncl_pkg.sv
// Dual-rail slot encoding shared by the clocked NCL counter and its digit stages.
package ncl_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL    = 2'b00;
  localparam dr_t DR_DATA0   = 2'b01;
  localparam dr_t DR_DATA1   = 2'b10;
  localparam dr_t DR_ILLEGAL = 2'b11;

  function automatic logic dr_is_data(input dr_t v);
    return (v == DR_DATA0) || (v == DR_DATA1);
  endfunction

  function automatic dr_t dr_from_bit(input logic b);
    return b ? DR_DATA1 : DR_DATA0;
  endfunction

endpackage

// File: rtl/ncl_sync_digit.sv
// One counter digit: holds its count bit and turns an incoming carry/borrow
// wavefront into the wavefront for the next digit.
module ncl_sync_digit
  import ncl_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       init,
  input  logic [1:0] slot_i,
  input  logic       dir_i,
  input  logic       next_full_i,
  input  logic       load_i,
  input  logic       load_bit_i,
  output logic       fire_c,
  output logic [1:0] carry_c,
  output logic       count_o
);

  logic count_q;
  logic count_d;
  logic c;
  logic carry;

  // A DATA0 wavefront still fires so every digit observes every step.
  always_comb begin
    c       = (slot_i == DR_DATA1);
    fire_c  = dr_is_data(slot_i) && !next_full_i;
    carry   = dir_i ? (~count_q & c) : (count_q & c);
    carry_c = fire_c ? dr_from_bit(carry) : DR_NULL;
    count_d = count_q;
    if (load_i) begin
      count_d = load_bit_i;
    end else if (fire_c) begin
      count_d = count_q ^ c;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      count_q <= RESET_BIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ncl_sync_digit_counter.sv
// Clocked digit-pipelined NCL counter: up/down wavefronts ripple one digit per
// clock through dual-rail carry slots, with parallel load and a carry-out handshake.
module ncl_sync_digit_counter
  import ncl_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter bit               AUTO_CONSUME = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             init,
  input  logic             inc_valid,
  input  logic             inc_dir,
  output logic             inc_ready,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             count_stable,
  output logic             cout_valid,
  output logic             cout_bit,
  output logic             cout_dir,
  input  logic             cout_ready
);

  logic [WIDTH:0][1:0]   slot_q;
  logic [WIDTH:0][1:0]   slot_d;
  logic [WIDTH:0]        dir_q;
  logic [WIDTH:0]        dir_d;
  logic [WIDTH-1:0][1:0] carry;
  logic [WIDTH-1:0]      fire;
  logic                  load_en;
  logic                  accept;
  logic                  cout_clear;
  logic                  illegal_slot;

  // Load only applies to a quiescent pipeline and takes priority over a request.
  assign count_stable = !init && (slot_q[WIDTH-1:0] == '0);
  assign load_en      = load && count_stable;
  assign inc_ready    = !init && (slot_q[0] == DR_NULL) && !load_en;
  assign accept       = inc_valid && inc_ready;

  assign cout_valid = (slot_q[WIDTH] != DR_NULL);
  assign cout_bit   = slot_q[WIDTH][1];
  assign cout_dir   = dir_q[WIDTH];
  assign cout_clear = cout_valid && (AUTO_CONSUME || cout_ready);

  for (genvar i = 0; i < WIDTH; i++) begin : g_digit
    ncl_sync_digit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_digit (
      .clk         (clk),
      .init        (init),
      .slot_i      (slot_q[i]),
      .dir_i       (dir_q[i]),
      .next_full_i (slot_q[i+1] != DR_NULL),
      .load_i      (load_en),
      .load_bit_i  (load_value[i]),
      .fire_c      (fire[i]),
      .carry_c     (carry[i]),
      .count_o     (count[i])
    );
  end

  // Fire, fill and drain conditions on any one slot are mutually exclusive.
  always_comb begin
    slot_d = slot_q;
    dir_d  = dir_q;
    if (accept) begin
      slot_d[0] = DR_DATA1;
      dir_d[0]  = inc_dir;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (fire[i]) begin
        slot_d[i]   = DR_NULL;
        slot_d[i+1] = carry[i];
        dir_d[i+1]  = dir_q[i];
      end
    end
    if (cout_clear) begin
      slot_d[WIDTH] = DR_NULL;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      slot_q <= '0;
      dir_q  <= '0;
    end else begin
      slot_q <= slot_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    illegal_slot = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (slot_q[i] == DR_ILLEGAL) begin
        illegal_slot = 1'b1;
      end
    end
  end

  a_no_illegal_slot : assert property (@(posedge clk) disable iff (init) !illegal_slot);

endmodule

// File: tb/tb_ncl_sync_digit_counter.sv
// Scoreboarded bench for ncl_sync_digit_counter: one auto-consume and one
// handshake-consume instance sharing clock and init.
module tb_ncl_sync_digit_counter;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'h00;

  logic clk = 1'b0;
  logic init;

  logic         a_inc_valid, a_inc_dir, a_inc_ready, a_load;
  logic [W-1:0] a_load_value, a_count;
  logic         a_count_stable, a_cout_valid, a_cout_bit, a_cout_dir, a_cout_ready;

  logic         m_inc_valid, m_inc_dir, m_inc_ready, m_load;
  logic [W-1:0] m_load_value, m_count;
  logic         m_count_stable, m_cout_valid, m_cout_bit, m_cout_dir, m_cout_ready;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [1:0]   a_q[$];
  logic [1:0]   m_q[$];
  logic [W-1:0] a_model, m_model;
  logic         dummy;

  always #5 clk = ~clk;

  ncl_sync_digit_counter #(.WIDTH(W), .AUTO_CONSUME(1'b1), .RESET_VALUE(RV)) u_auto (
    .clk(clk), .init(init), .inc_valid(a_inc_valid), .inc_dir(a_inc_dir), .inc_ready(a_inc_ready),
    .load(a_load), .load_value(a_load_value), .count(a_count), .count_stable(a_count_stable),
    .cout_valid(a_cout_valid), .cout_bit(a_cout_bit), .cout_dir(a_cout_dir), .cout_ready(a_cout_ready)
  );

  ncl_sync_digit_counter #(.WIDTH(W), .AUTO_CONSUME(1'b0), .RESET_VALUE(RV)) u_man (
    .clk(clk), .init(init), .inc_valid(m_inc_valid), .inc_dir(m_inc_dir), .inc_ready(m_inc_ready),
    .load(m_load), .load_value(m_load_value), .count(m_count), .count_stable(m_count_stable),
    .cout_valid(m_cout_valid), .cout_bit(m_cout_bit), .cout_dir(m_cout_dir), .cout_ready(m_cout_ready)
  );

  // Carry-out scoreboards: {cout_bit, cout_dir} popped as each cout is consumed.
  always @(negedge clk) begin
    if (!init && a_cout_valid) begin
      n_checks++;
      if (a_q.size() == 0) begin
        $display("FAIL a_cout_unexpected: got bit=%b dir=%b with nothing pending", a_cout_bit, a_cout_dir);
      end else if ({a_cout_bit, a_cout_dir} !== a_q[0]) begin
        $display("FAIL a_cout: got %b expected %b", {a_cout_bit, a_cout_dir}, a_q[0]);
        void'(a_q.pop_front());
      end else begin
        n_pass++;
        void'(a_q.pop_front());
      end
    end
    if (!init && m_cout_valid && m_cout_ready) begin
      n_checks++;
      if (m_q.size() == 0) begin
        $display("FAIL m_cout_unexpected: got bit=%b dir=%b with nothing pending", m_cout_bit, m_cout_dir);
      end else if ({m_cout_bit, m_cout_dir} !== m_q[0]) begin
        $display("FAIL m_cout: got %b expected %b", {m_cout_bit, m_cout_dir}, m_q[0]);
        void'(m_q.pop_front());
      end else begin
        n_pass++;
        void'(m_q.pop_front());
      end
    end
  end

  task automatic a_cyc(input logic v, input logic d, input logic ld, input logic [W-1:0] lv,
                       output logic acc);
    @(negedge clk);
    a_inc_valid = v; a_inc_dir = d; a_load = ld; a_load_value = lv;
    #1;
    acc = v && a_inc_ready;
    if (ld && a_count_stable) a_model = lv;
    if (acc) begin
      a_q.push_back({d ? (a_model == '0) : (a_model == '1), d});
      a_model = d ? a_model - 1'b1 : a_model + 1'b1;
    end
  endtask

  task automatic m_cyc(input logic v, input logic d, output logic acc);
    @(negedge clk);
    m_inc_valid = v; m_inc_dir = d; m_load = 1'b0; m_load_value = '0;
    #1;
    acc = v && m_inc_ready;
    if (acc) begin
      m_q.push_back({d ? (m_model == '0) : (m_model == '1), d});
      m_model = d ? m_model - 1'b1 : m_model + 1'b1;
    end
  endtask

  task automatic a_idle();
    a_cyc(1'b0, 1'b0, 1'b0, '0, dummy);
  endtask

  task automatic a_req(input logic d);
    logic acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) a_cyc(1'b1, d, 1'b0, '0, acc);
    a_idle();
    n_checks++;
    if (!acc) $display("FAIL a_req_timeout: request dir=%b never accepted", d);
    else n_pass++;
  endtask

  task automatic a_drain();
    int k = 0;
    while (!(a_count_stable && !a_cout_valid) && k < 64) begin
      a_idle();
      k++;
    end
    n_checks++;
    if (!(a_count_stable && !a_cout_valid))
      $display("FAIL a_drain_timeout: count_stable=%b cout_valid=%b", a_count_stable, a_cout_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    init = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({a_count, a_inc_ready, a_cout_valid} !== {RV, 1'b0, 1'b0})
      $display("FAIL reset_hold: got count=%h rdy=%b cv=%b expected %h 0 0", a_count, a_inc_ready, a_cout_valid, RV);
    else n_pass++;
    @(negedge clk); init = 1'b0; #1;
    a_model = RV; m_model = RV;
    n_checks++;
    if ({a_count, a_count_stable, a_inc_ready} !== {RV, 1'b1, 1'b1})
      $display("FAIL reset_release: got count=%h stable=%b rdy=%b expected %h 1 1", a_count, a_count_stable, a_inc_ready, RV);
    else n_pass++;
  endtask

  task automatic test_single_inc();
    logic acc = 1'b0;
    while (!acc) a_cyc(1'b1, 1'b0, 1'b0, '0, acc);
    for (int k = 1; k <= 10; k++) begin
      a_idle();
      if (k == 1) begin
        n_checks++;
        if (a_count !== 8'h00) $display("FAIL single_t0: got %h expected 00", a_count);
        else n_pass++;
      end
      if (k == 2) begin
        n_checks++;
        if (a_count !== 8'h01) $display("FAIL single_t1: got %h expected 01", a_count);
        else n_pass++;
      end
      if (k == 8 || k == 9 || k == 10) begin
        n_checks++;
        if (a_cout_valid !== (k == 9)) $display("FAIL single_cout_k%0d: got cout_valid=%b expected %b", k, a_cout_valid, k == 9);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    a_cyc(1'b0, 1'b0, 1'b1, 8'hFF, dummy);
    n_checks++;
    if (a_inc_ready !== 1'b0) $display("FAIL load_wins: got inc_ready=%b expected 0", a_inc_ready);
    else n_pass++;
    a_idle();
    a_req(1'b0);
    a_drain();
    n_checks++;
    if (a_count !== 8'h00) $display("FAIL wrap_up: got %h expected 00", a_count);
    else n_pass++;
    a_cyc(1'b0, 1'b0, 1'b1, 8'h00, dummy);
    a_idle();
    a_req(1'b1);
    a_drain();
    n_checks++;
    if (a_count !== 8'hFF) $display("FAIL wrap_down: got %h expected FF", a_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   n_acc = 0;
    a_cyc(1'b0, 1'b0, 1'b1, 8'h00, dummy);
    a_idle();
    for (int k = 0; k < 20; k++) begin
      a_cyc(1'b1, 1'b0, 1'b0, '0, acc);
      if (acc) n_acc++;
    end
    a_idle();
    a_drain();
    n_checks++;
    if (n_acc != 10) $display("FAIL b2b_accepted: got %0d expected 10", n_acc);
    else n_pass++;
    n_checks++;
    if ({a_count, a_count_stable} !== {8'h0A, 1'b1})
      $display("FAIL b2b_count: got %h stable=%b expected 0a 1", a_count, a_count_stable);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic acc;
    int   n_acc = 0;
    int   k = 0;
    m_cout_ready = 1'b0;
    for (int j = 0; j < 50; j++) begin
      m_cyc(1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    n_checks++;
    if (n_acc != 9 || m_inc_ready !== 1'b0)
      $display("FAIL bp_fill: got accepted=%0d inc_ready=%b expected 9 0", n_acc, m_inc_ready);
    else n_pass++;
    m_cout_ready = 1'b1;
    while (n_acc < 12 && k < 60) begin
      m_cyc(1'b1, 1'b0, acc);
      if (acc) n_acc++;
      k++;
    end
    k = 0;
    m_cyc(1'b0, 1'b0, acc);
    while (!(m_count_stable && !m_cout_valid) && k < 64) begin
      m_cyc(1'b0, 1'b0, acc);
      k++;
    end
    n_checks++;
    if (n_acc != 12 || m_count !== 8'h0C || m_count_stable !== 1'b1)
      $display("FAIL bp_drain: got accepted=%0d count=%h stable=%b expected 12 0c 1", n_acc, m_count, m_count_stable);
    else n_pass++;
  endtask

  task automatic test_mixed();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    a_model = RV; m_model = RV;
    a_req(1'b0); a_req(1'b1); a_req(1'b0); a_req(1'b0);
    a_drain();
    n_checks++;
    if (a_count !== RV + 8'd2) $display("FAIL mixed_plus2: got %h expected %h", a_count, RV + 8'd2);
    else n_pass++;
    a_cyc(1'b0, 1'b0, 1'b1, 8'hFF, dummy);
    a_idle();
    a_req(1'b1); a_req(1'b0); a_req(1'b0); a_req(1'b1); a_req(1'b0);
    a_drain();
    n_checks++;
    if (a_count !== 8'h00) $display("FAIL mixed_wrap: got %h expected 00", a_count);
    else n_pass++;
  endtask

  task automatic test_init_midflight();
    a_cyc(1'b0, 1'b0, 1'b1, 8'h33, dummy);
    a_idle();
    a_req(1'b0); a_req(1'b0); a_req(1'b1);
    @(negedge clk);
    init = 1'b1; a_inc_valid = 1'b0;
    #1;
    a_q.delete(); m_q.delete();
    a_model = RV; m_model = RV;
    n_checks++;
    if ({a_count, a_inc_ready, a_cout_valid} !== {RV, 1'b0, 1'b0})
      $display("FAIL init_mid: got count=%h rdy=%b cv=%b expected %h 0 0", a_count, a_inc_ready, a_cout_valid, RV);
    else n_pass++;
    @(negedge clk); init = 1'b0;
    for (int k = 0; k < 12; k++) a_idle();
    n_checks++;
    if ({a_count, a_count_stable, a_cout_valid} !== {RV, 1'b1, 1'b0})
      $display("FAIL init_after: got count=%h stable=%b cv=%b expected %h 1 0", a_count, a_count_stable, a_cout_valid, RV);
    else n_pass++;
  endtask

  task automatic test_load();
    a_req(1'b0);
    a_cyc(1'b0, 1'b0, 1'b1, 8'hA5, dummy);
    n_checks++;
    if (a_count_stable !== 1'b0) $display("FAIL load_unstable_pre: got stable=%b expected 0", a_count_stable);
    else n_pass++;
    a_idle();
    a_drain();
    n_checks++;
    if (a_count !== RV + 8'd1) $display("FAIL load_ignored: got %h expected %h", a_count, RV + 8'd1);
    else n_pass++;
    a_cyc(1'b0, 1'b0, 1'b1, 8'h5A, dummy);
    a_idle();
    n_checks++;
    if (a_count !== 8'h5A) $display("FAIL load_stable: got %h expected 5a", a_count);
    else n_pass++;
  endtask

  initial begin
    init = 1'b1;
    a_inc_valid = 1'b0; a_inc_dir = 1'b0; a_load = 1'b0; a_load_value = '0; a_cout_ready = 1'b0;
    m_inc_valid = 1'b0; m_inc_dir = 1'b0; m_load = 1'b0; m_load_value = '0; m_cout_ready = 1'b1;
    a_model = RV; m_model = RV; dummy = 1'b0;
    test_reset();
    test_single_inc();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_mixed();
    test_init_midflight();
    test_load();
    for (int k = 0; k < 4; k++) a_idle();
    n_checks++;
    if (a_q.size() != 0 || m_q.size() != 0 || a_count !== a_model)
      $display("FAIL final: pending a=%0d m=%0d count=%h model=%h", a_q.size(), m_q.size(), a_count, a_model);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
